// File: rtl/fd_pipe_if.sv
// Fetch/decode pipeline register bundle: fetch-side inputs, flush controls and decode-side outputs.
interface fd_pipe_if #(
    parameter int unsigned WIDTH_32 = 32,
    parameter int unsigned CNT_W    = 16
);
    logic                EN;
    logic                CLR;
    logic                EXC;
    logic                VALID_F;
    logic [WIDTH_32-1:0] PC_F;
    logic [WIDTH_32-1:0] PC_plus_4_F;
    logic [WIDTH_32-1:0] INSTRUCTION_F;
    logic                VALID_D;
    logic [WIDTH_32-1:0] PC_D;
    logic [WIDTH_32-1:0] PC_plus_4_D;
    logic [WIDTH_32-1:0] INSTRUCTION_D;
    logic [WIDTH_32-1:0] EPC;
    logic                EXC_TAKEN;
    logic [CNT_W-1:0]    FLUSH_CNT;

    modport master (
        output EN, CLR, EXC, VALID_F, PC_F, PC_plus_4_F, INSTRUCTION_F,
        input  VALID_D, PC_D, PC_plus_4_D, INSTRUCTION_D, EPC, EXC_TAKEN, FLUSH_CNT
    );

    modport slave (
        input  EN, CLR, EXC, VALID_F, PC_F, PC_plus_4_F, INSTRUCTION_F,
        output VALID_D, PC_D, PC_plus_4_D, INSTRUCTION_D, EPC, EXC_TAKEN, FLUSH_CNT
    );
endinterface

// File: rtl/fd_pipe_stage.sv
// Multi-stage fetch/decode pipeline register with stall, branch flush, exception flush,
// EPC capture and a saturating count of killed instructions.
module fd_pipe_stage #(
    parameter int unsigned WIDTH_32 = 32,
    parameter int unsigned DEPTH    = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic         clk,
    input logic         rst_n,
    fd_pipe_if.slave    bus
);
    if (DEPTH < 1 || DEPTH > 4) begin : gen_depth_check
        $error("fd_pipe_stage: DEPTH must be in 1..4");
    end

    // Three spare bits hold CNT + up to four kills without overflow.
    localparam int unsigned SumW = CNT_W + 3;
    localparam logic [SumW-1:0] CntMax = SumW'({CNT_W{1'b1}});

    logic [DEPTH-1:0]    valid_q;
    logic [WIDTH_32-1:0] pc_q    [DEPTH];
    logic [WIDTH_32-1:0] pc4_q   [DEPTH];
    logic [WIDTH_32-1:0] instr_q [DEPTH];
    logic [WIDTH_32-1:0] epc_q;
    logic                exc_taken_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [2:0]          killed;
    logic [WIDTH_32-1:0] oldest_pc;
    logic [SumW-1:0]     cnt_sum;
    logic [CNT_W-1:0]    cnt_d;

    always_comb begin
        killed    = '0;
        oldest_pc = bus.PC_F;
        // Later (older) stages overwrite earlier ones, so the oldest valid PC wins.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            killed = killed + 3'(valid_q[i]);
            if (valid_q[i]) begin
                oldest_pc = pc_q[i];
            end
        end
        cnt_sum = SumW'(cnt_q) + SumW'(killed);
        cnt_d   = (cnt_sum > CntMax) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            epc_q       <= '0;
            exc_taken_q <= 1'b0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                pc4_q[i]   <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            exc_taken_q <= bus.EXC;
            if (bus.EXC || bus.CLR) begin
                valid_q <= '0;
                cnt_q   <= cnt_d;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    pc_q[i]    <= '0;
                    pc4_q[i]   <= '0;
                    instr_q[i] <= '0;
                end
                if (bus.EXC) begin
                    epc_q <= oldest_pc;
                end
            end else if (bus.EN) begin
                valid_q[0] <= bus.VALID_F;
                pc_q[0]    <= bus.PC_F;
                pc4_q[0]   <= bus.PC_plus_4_F;
                instr_q[0] <= bus.INSTRUCTION_F;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    pc_q[i]    <= pc_q[i-1];
                    pc4_q[i]   <= pc4_q[i-1];
                    instr_q[i] <= instr_q[i-1];
                end
            end
        end
    end

    assign bus.VALID_D       = valid_q[DEPTH-1];
    assign bus.PC_D          = pc_q[DEPTH-1];
    assign bus.PC_plus_4_D   = pc4_q[DEPTH-1];
    assign bus.INSTRUCTION_D = instr_q[DEPTH-1];
    assign bus.EPC           = epc_q;
    assign bus.EXC_TAKEN     = exc_taken_q;
    assign bus.FLUSH_CNT     = cnt_q;
endmodule

// File: tb/tb_fd_pipe_stage.sv
// Directed bench for fd_pipe_stage: vector table on a DEPTH=2 instance, hand sequences on
// DEPTH=3 (exception) and DEPTH=1/CNT_W=2 (saturation), plus asynchronous reset.
module tb_fd_pipe_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fd_pipe_if #(.WIDTH_32(32), .CNT_W(16)) if2 ();
    fd_pipe_if #(.WIDTH_32(32), .CNT_W(16)) if3 ();
    fd_pipe_if #(.WIDTH_32(32), .CNT_W(2))  if1 ();

    fd_pipe_stage #(.WIDTH_32(32), .DEPTH(2), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));
    fd_pipe_stage #(.WIDTH_32(32), .DEPTH(3), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave));
    fd_pipe_stage #(.WIDTH_32(32), .DEPTH(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en, clr, exc, vf;
        logic [31:0] pc;
        logic        e_vd;
        logic [31:0] e_pc, e_pc4, e_ins, e_epc;
        logic        e_et;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0093};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_sat[4];
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        {if2.EN, if2.CLR, if2.EXC, if2.VALID_F} = 4'b0;
        {if3.EN, if3.CLR, if3.EXC, if3.VALID_F} = 4'b0;
        {if1.EN, if1.CLR, if1.EXC, if1.VALID_F} = 4'b0;
        if2.PC_F = '0; if2.PC_plus_4_F = '0; if2.INSTRUCTION_F = '0;
        if3.PC_F = '0; if3.PC_plus_4_F = '0; if3.INSTRUCTION_F = '0;
        if1.PC_F = '0; if1.PC_plus_4_F = '0; if1.INSTRUCTION_F = '0;

        //            en clr exc vf pc        vd  pc_d     pc4_d    ins_d            epc      et cnt
        vecs[0]  = '{1, 0, 0, 1, 32'h100, 0, 32'h0,   32'h0,   32'h0,           32'h0,   0, 16'd0};
        vecs[1]  = '{1, 0, 0, 1, 32'h104, 1, 32'h100, 32'h104, ins_of(32'h100), 32'h0,   0, 16'd0};
        vecs[2]  = '{1, 0, 0, 1, 32'h108, 1, 32'h104, 32'h108, ins_of(32'h104), 32'h0,   0, 16'd0};
        vecs[3]  = '{0, 0, 0, 1, 32'h10C, 1, 32'h104, 32'h108, ins_of(32'h104), 32'h0,   0, 16'd0};
        vecs[4]  = '{0, 0, 0, 1, 32'h10C, 1, 32'h104, 32'h108, ins_of(32'h104), 32'h0,   0, 16'd0};
        vecs[5]  = '{0, 0, 0, 1, 32'h10C, 1, 32'h104, 32'h108, ins_of(32'h104), 32'h0,   0, 16'd0};
        vecs[6]  = '{1, 0, 0, 1, 32'h10C, 1, 32'h108, 32'h10C, ins_of(32'h108), 32'h0,   0, 16'd0};
        vecs[7]  = '{0, 1, 0, 1, 32'h110, 0, 32'h0,   32'h0,   32'h0,           32'h0,   0, 16'd2};
        vecs[8]  = '{1, 0, 0, 0, 32'h200, 0, 32'h0,   32'h0,   32'h0,           32'h0,   0, 16'd2};
        vecs[9]  = '{1, 0, 0, 1, 32'h204, 0, 32'h200, 32'h204, ins_of(32'h200), 32'h0,   0, 16'd2};
        vecs[10] = '{1, 0, 1, 1, 32'h208, 0, 32'h0,   32'h0,   32'h0,           32'h204, 1, 16'd3};
        vecs[11] = '{1, 0, 0, 1, 32'h20C, 0, 32'h0,   32'h0,   32'h0,           32'h204, 0, 16'd3};
        vecs[12] = '{0, 1, 1, 1, 32'h300, 0, 32'h0,   32'h0,   32'h0,           32'h20C, 1, 16'd4};
        vecs[13] = '{0, 0, 1, 0, 32'h400, 0, 32'h0,   32'h0,   32'h0,           32'h400, 1, 16'd4};
        vecs[14] = '{0, 0, 0, 0, 32'h0,   0, 32'h0,   32'h0,   32'h0,           32'h400, 0, 16'd4};

        #2;
        chk("reset valid_d", 32'(if2.VALID_D), 32'h0);
        chk("reset pc_d", if2.PC_D, 32'h0);
        chk("reset epc", if2.EPC, 32'h0);
        chk("reset exc_taken", 32'(if2.EXC_TAKEN), 32'h0);
        chk("reset flush_cnt", 32'(if2.FLUSH_CNT), 32'h0);
        #10 rst_n = 1'b1;

        // DEPTH=2 vector table: streaming, stall, flush in stall, exceptions
        for (int i = 0; i < 15; i++) begin
            if2.EN            = vecs[i].en;
            if2.CLR           = vecs[i].clr;
            if2.EXC           = vecs[i].exc;
            if2.VALID_F       = vecs[i].vf;
            if2.PC_F          = vecs[i].pc;
            if2.PC_plus_4_F   = vecs[i].pc + 32'd4;
            if2.INSTRUCTION_F = ins_of(vecs[i].pc);
            tick();
            chk($sformatf("vec%0d valid_d", i), 32'(if2.VALID_D), 32'(vecs[i].e_vd));
            chk($sformatf("vec%0d pc_d", i), if2.PC_D, vecs[i].e_pc);
            chk($sformatf("vec%0d pc4_d", i), if2.PC_plus_4_D, vecs[i].e_pc4);
            chk($sformatf("vec%0d ins_d", i), if2.INSTRUCTION_D, vecs[i].e_ins);
            chk($sformatf("vec%0d epc", i), if2.EPC, vecs[i].e_epc);
            chk($sformatf("vec%0d exc_taken", i), 32'(if2.EXC_TAKEN), 32'(vecs[i].e_et));
            chk($sformatf("vec%0d flush_cnt", i), 32'(if2.FLUSH_CNT), 32'(vecs[i].e_cnt));
        end

        // DEPTH=3: stage2 invalid, stage1 holds 0x200, stage0 invalid
        if3.EN = 1'b1; if3.VALID_F = 1'b1; if3.PC_F = 32'h200;
        tick();
        if3.VALID_F = 1'b0; if3.PC_F = 32'h204;
        tick();
        if3.EXC = 1'b1; if3.VALID_F = 1'b1; if3.PC_F = 32'h500;
        tick();
        chk("d3 exc epc", if3.EPC, 32'h200);
        chk("d3 exc taken", 32'(if3.EXC_TAKEN), 32'h1);
        chk("d3 exc valid_d", 32'(if3.VALID_D), 32'h0);
        chk("d3 exc cnt", 32'(if3.FLUSH_CNT), 32'h1);
        if3.EXC = 1'b0; if3.VALID_F = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("d3 drain%0d valid_d", k), 32'(if3.VALID_D), 32'h0);
            chk($sformatf("d3 drain%0d exc_taken", k), 32'(if3.EXC_TAKEN), 32'h0);
        end
        if3.EN = 1'b0; if3.EXC = 1'b1; if3.PC_F = 32'h300;
        tick();
        chk("d3 empty epc", if3.EPC, 32'h300);
        chk("d3 empty cnt", 32'(if3.FLUSH_CNT), 32'h1);
        chk("d3 empty taken", 32'(if3.EXC_TAKEN), 32'h1);
        if3.EXC = 1'b0;
        tick();
        chk("d3 taken pulse end", 32'(if3.EXC_TAKEN), 32'h0);

        // DEPTH=1, CNT_W=2: saturation; incoming VALID_F during CLR is not counted
        exp_sat = '{1, 2, 3, 3};
        for (int k = 0; k < 4; k++) begin
            if1.CLR = 1'b0; if1.EN = 1'b1; if1.VALID_F = 1'b1; if1.PC_F = 32'(k * 4);
            tick();
            chk($sformatf("sat%0d loaded", k), 32'(if1.VALID_D), 32'h1);
            if1.CLR = 1'b1;
            tick();
            chk($sformatf("sat%0d cnt", k), 32'(if1.FLUSH_CNT), 32'(exp_sat[k]));
            chk($sformatf("sat%0d valid_d", k), 32'(if1.VALID_D), 32'h0);
        end
        if1.CLR = 1'b0;

        // Asynchronous reset with full pipelines
        if2.EN = 1'b1; if2.VALID_F = 1'b1; if2.PC_F = 32'h600;
        if2.PC_plus_4_F = 32'h604; if2.INSTRUCTION_F = ins_of(32'h600);
        tick();
        if2.PC_F = 32'h604; if2.PC_plus_4_F = 32'h608; if2.INSTRUCTION_F = ins_of(32'h604);
        tick();
        chk("pre-rst valid_d", 32'(if2.VALID_D), 32'h1);
        chk("pre-rst pc_d", if2.PC_D, 32'h600);
        #3 rst_n = 1'b0;
        #1;
        chk("arst valid_d", 32'(if2.VALID_D), 32'h0);
        chk("arst pc_d", if2.PC_D, 32'h0);
        chk("arst pc4_d", if2.PC_plus_4_D, 32'h0);
        chk("arst ins_d", if2.INSTRUCTION_D, 32'h0);
        chk("arst epc", if2.EPC, 32'h0);
        chk("arst cnt", 32'(if2.FLUSH_CNT), 32'h0);
        chk("arst d3 epc", if3.EPC, 32'h0);
        chk("arst d1 cnt", 32'(if1.FLUSH_CNT), 32'h0);
        if1.EN = 1'b1; if1.VALID_F = 1'b1; if1.PC_F = 32'h44;
        tick();
        tick();
        chk("rst held valid_d", 32'(if2.VALID_D), 32'h0);
        chk("rst held pc_d", if2.PC_D, 32'h0);
        chk("rst held d1 valid_d", 32'(if1.VALID_D), 32'h0);
        #3 rst_n = 1'b1;
        tick();
        chk("post-rst d1 valid_d", 32'(if1.VALID_D), 32'h1);
        chk("post-rst d1 pc_d", if1.PC_D, 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
